// File: rtl/led_pattern_engine_if.sv
// Configuration write channel for led_pattern_engine: one write per clk when
// cfg_valid & cfg_ready.
interface led_pattern_engine_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_engine.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM patterns advanced by a
// shared prescaled tick, with a global phase-restart input.
module led_pattern_engine #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    led_pattern_engine_if.slave  cfg,
    input  logic                 sync,
    output logic [NUM_CH-1:0]    led,
    output logic [NUM_CH-1:0]    frame_pulse
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeOn    = 2'd1,
        ModeBlink = 2'd2,
        ModePwm   = 2'd3
    } mode_e;

    if (NUM_CH < 1) begin : g_bad_num_ch
        $fatal(1, "led_pattern_engine: NUM_CH must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $fatal(1, "led_pattern_engine: CNT_W must be 1..32");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "led_pattern_engine: PRESCALE must be >= 1");
    end

    logic [PS_W-1:0]   ps_q, ps_d;
    logic              ready_q;
    logic              tick;
    logic              wr_en;
    mode_e             mode_q   [NUM_CH];
    mode_e             mode_d   [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  duty_q   [NUM_CH];
    logic [CNT_W-1:0]  duty_d   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] fp_q, fp_d;

    // LED level a channel starts from after a write or a sync restart.
    function automatic logic init_led(mode_e m, logic [CNT_W-1:0] d);
        return (m == ModeOn) || ((m == ModePwm) && (d != '0));
    endfunction

    assign tick  = (ps_q == PS_W'(PRESCALE - 1));
    assign wr_en = cfg.cfg_valid && ready_q && (int'(cfg.cfg_ch) < NUM_CH);

    always_comb begin
        ps_d = (sync || tick) ? '0 : ps_q + 1'b1;
        led_d = led_q;
        fp_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            duty_d[i]   = duty_q[i];
            cnt_d[i]    = cnt_q[i];

            unique case (mode_q[i])
                ModeOff: begin
                    led_d[i] = 1'b0;
                    cnt_d[i] = '0;
                end
                ModeOn: begin
                    led_d[i] = 1'b1;
                    cnt_d[i] = '0;
                end
                ModeBlink: begin
                    if (tick) begin
                        if (cnt_q[i] == period_q[i]) begin
                            led_d[i] = ~led_q[i];
                            cnt_d[i] = '0;
                            fp_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                ModePwm: begin
                    if (tick) begin
                        cnt_d[i] = (cnt_q[i] == period_q[i]) ? '0 : cnt_q[i] + 1'b1;
                        led_d[i] = cnt_d[i] < duty_q[i];
                        fp_d[i]  = (cnt_q[i] == period_q[i]);
                    end
                end
            endcase

            if (sync) begin
                cnt_d[i] = '0;
                led_d[i] = init_led(mode_q[i], duty_q[i]);
                fp_d[i]  = 1'b0;
            end

            // A write wins over the pattern update and also over sync for its channel.
            if (wr_en && (int'(cfg.cfg_ch) == i)) begin
                mode_d[i]   = mode_e'(cfg.cfg_mode);
                period_d[i] = cfg.cfg_period;
                duty_d[i]   = cfg.cfg_duty;
                cnt_d[i]    = '0;
                led_d[i]    = init_led(mode_e'(cfg.cfg_mode), cfg.cfg_duty);
                fp_d[i]     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q    <= '0;
            ready_q <= 1'b0;
            led_q   <= '0;
            fp_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= ModeOff;
                period_q[i] <= '0;
                duty_q[i]   <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            ps_q    <= ps_d;
            ready_q <= 1'b1;
            led_q   <= led_d;
            fp_q    <= fp_d;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                duty_q[i]   <= duty_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign led           = led_q;
    assign frame_pulse   = fp_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: two instances (PRESCALE 1 and 4) share stimulus and
// are checked every cycle against a tick-count model, plus hand-computed patterns.
module tb_led_pattern_engine;
    localparam int NC = 5;
    localparam int CW = 16;
    localparam int PS [2] = '{1, 4};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync = 1'b0;
    logic [NC-1:0] led0, led1, fp0, fp1;

    int checks = 0;
    int failures = 0;

    led_pattern_engine_if #(.NUM_CH(NC), .CNT_W(CW)) if0 ();
    led_pattern_engine_if #(.NUM_CH(NC), .CNT_W(CW)) if1 ();

    led_pattern_engine #(.NUM_CH(NC), .CNT_W(CW), .PRESCALE(1)) dut0 (
        .clk(clk), .reset(rst_n), .cfg(if0), .sync(sync), .led(led0), .frame_pulse(fp0)
    );
    led_pattern_engine #(.NUM_CH(NC), .CNT_W(CW), .PRESCALE(4)) dut1 (
        .clk(clk), .reset(rst_n), .cfg(if1), .sync(sync), .led(led1), .frame_pulse(fp1)
    );

    always #5 clk = ~clk;

    // Model: each channel is described by ticks elapsed since its last restart.
    int     m_mode [2][NC];
    longint m_per  [2][NC];
    longint m_duty [2][NC];
    longint m_t    [2][NC];
    bit     m_fp   [2][NC];
    longint m_pc   [2];
    bit     m_ready[2];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_led(int d, int c);
        longint p = m_per[d][c] + 1;
        case (m_mode[d][c])
            0: return 1'b0;
            1: return 1'b1;
            2: return ((m_t[d][c] / p) % 2) == 1;
            default: return (m_t[d][c] % p) < m_duty[d][c];
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 0;
            m_ready[d] = 1'b0;
            for (int c = 0; c < NC; c++) begin
                m_mode[d][c] = 0; m_per[d][c] = 0; m_duty[d][c] = 0;
                m_t[d][c] = 0; m_fp[d][c] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(int d, bit v, int ch, int mode, int per, int duty, bit s);
        bit tick;
        if (!rst_n) return;
        tick = (m_pc[d] % PS[d]) == PS[d] - 1;
        m_pc[d]++;
        for (int c = 0; c < NC; c++) begin
            m_fp[d][c] = 1'b0;
            if (tick) begin
                m_t[d][c]++;
                if (m_mode[d][c] >= 2 && (m_t[d][c] % (m_per[d][c] + 1)) == 0)
                    m_fp[d][c] = 1'b1;
            end
            if (s) begin
                m_t[d][c] = 0;
                m_fp[d][c] = 1'b0;
            end
        end
        if (s) m_pc[d] = 0;
        if (v && m_ready[d] && ch < NC) begin
            m_mode[d][ch] = mode; m_per[d][ch] = per; m_duty[d][ch] = duty;
            m_t[d][ch] = 0; m_fp[d][ch] = 1'b0;
        end
        m_ready[d] = 1'b1;
    endtask

    task automatic cycle(bit v, int ch, int mode, int per, int duty, bit s);
        if0.cfg_valid = v;  if0.cfg_ch = 3'(ch); if0.cfg_mode = 2'(mode);
        if0.cfg_period = CW'(per); if0.cfg_duty = CW'(duty);
        if1.cfg_valid = v;  if1.cfg_ch = 3'(ch); if1.cfg_mode = 2'(mode);
        if1.cfg_period = CW'(per); if1.cfg_duty = CW'(duty);
        sync = s;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d, v, ch, mode, per, duty, s);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    // Every-cycle comparison of both instances against the model.
    logic [NC-1:0] exp_led, exp_fp;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                exp_led[c] = model_led(d, c);
                exp_fp[c]  = m_fp[d][c];
            end
            check($sformatf("led_dut%0d", d), (d == 0) ? led0 : led1, exp_led);
            check($sformatf("frame_pulse_dut%0d", d), (d == 0) ? fp0 : fp1, exp_fp);
            check($sformatf("cfg_ready_dut%0d", d),
                  (d == 0) ? if0.cfg_ready : if1.cfg_ready, m_ready[d]);
        end
    end

    initial begin
        logic [23:0] pat;
        logic [7:0]  fpat;
        int          cnt_hi, cnt_fp, mism;

        model_reset();
        if0.cfg_valid = 0; if0.cfg_ch = 0; if0.cfg_mode = 0; if0.cfg_period = 0;
        if0.cfg_duty = 0;
        if1.cfg_valid = 0; if1.cfg_ch = 0; if1.cfg_mode = 0; if1.cfg_period = 0;
        if1.cfg_duty = 0;
        #1;
        check("reset_led", led0, 0);
        check("reset_ready", if0.cfg_ready, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        check("ready_after_release", if0.cfg_ready, 1);

        // ch0 BLINK period=3: four low, four high, pulse on the toggle.
        cycle(1'b1, 0, 2, 3, 0, 1'b0);
        pat = '0; fpat = '0;
        for (int i = 0; i < 8; i++) begin
            pat[i] = led0[0]; fpat[i] = fp0[0];
            idle(1);
        end
        check("blink_p3_led", pat[7:0], 8'hF0);
        check("blink_p3_pulse", fpat, 8'h10);

        // ch1 PWM period=9 with duty 3, 0 and 12 over two frames each.
        for (int k = 0; k < 3; k++) begin
            int dty;
            dty = (k == 0) ? 3 : (k == 1) ? 0 : 12;
            cycle(1'b1, 1, 3, 9, dty, 1'b0);
            cnt_hi = 0; cnt_fp = 0;
            for (int i = 0; i < 20; i++) begin
                cnt_hi += int'(led0[1]); cnt_fp += int'(fp0[1]);
                idle(1);
            end
            check($sformatf("pwm_high_duty%0d", dty), cnt_hi, (k == 0) ? 6 : (k == 1) ? 0 : 20);
            check($sformatf("pwm_pulses_duty%0d", dty), cnt_fp, 1);
        end

        // Prescale 4, ch2 BLINK period=1, written with sync to fix the tick phase.
        cycle(1'b1, 2, 2, 1, 0, 1'b1);
        pat = '0;
        for (int i = 0; i < 24; i++) begin
            pat[i] = led1[2];
            idle(1);
        end
        check("prescale4_blink", pat, 24'h00FF00);

        // Two BLINK channels written 2 clks apart, realigned by sync.
        cycle(1'b1, 0, 2, 5, 0, 1'b0);
        idle(1);
        cycle(1'b1, 1, 2, 5, 0, 1'b0);
        idle(3);
        cycle(1'b0, 0, 0, 0, 0, 1'b1);
        mism = 0;
        for (int i = 0; i < 30; i++) begin
            if (led0[0] != led0[1] || fp0[0] != fp0[1]) mism++;
            idle(1);
        end
        check("sync_alignment", mism, 0);

        // Out-of-range writes are dropped; in-range ON takes effect at the same edge.
        cycle(1'b1, 3, 0, 0, 0, 1'b0);
        cycle(1'b1, 4, 0, 0, 0, 1'b0);
        cycle(1'b1, 5, 1, 0, 0, 1'b0);
        cycle(1'b1, 7, 1, 0, 0, 1'b0);
        check("out_of_range_write", led0[4:3], 2'b00);
        cycle(1'b1, 3, 1, 0, 0, 1'b0);
        check("ch3_on", led0[3], 1);

        for (int i = 0; i < 3000; i++) begin
            int per;
            per = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300))
                                               : int'($urandom_range(0, 12));
            cycle($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)), per, int'($urandom_range(0, per + 3)),
                  $urandom_range(0, 29) == 0);
        end

        // Asynchronous reset in the high phase of a PWM pattern.
        cycle(1'b1, 0, 3, 9, 5, 1'b1);
        idle(2);
        check("pwm_high_before_reset", led0[0], 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_led", led0, 0);
        check("async_reset_pulse", fp0, 0);
        check("async_reset_ready", if0.cfg_ready, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("ready_after_rerelease", if0.cfg_ready, 1);
        idle(12);
        check("all_off_after_reset", led0 | led1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent LED channels; SHALL be >= 1, else elaboration $fatal.
REQ-002 Parameter CNT_W, default 16, width of per-channel period/duty counters; SHALL be 1..32, else elaboration $fatal.
REQ-003 Parameter PRESCALE, default 1, clk cycles per counting tick; SHALL be >= 1, else elaboration $fatal.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cfg_valid  input  1  configuration write request.
REQ-007 cfg_ready  output  1  write acceptance; a write is accepted at an edge where cfg_valid & cfg_ready.
REQ-008 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-009 cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
REQ-010 cfg_period  input  CNT_W  BLINK half-period / PWM frame length, minus one, in ticks.
REQ-011 cfg_duty  input  CNT_W  PWM high time in ticks.
REQ-012 sync  input  1  synchronous phase restart of all channels and prescaler.
REQ-013 led  output  NUM_CH  registered LED drive, one bit per channel.
REQ-014 frame_pulse  output  NUM_CH  one-clk pulse per channel on BLINK toggle or PWM frame wrap.

Function
REQ-015 Prescaler SHALL count 0..PRESCALE-1 and assert internal tick for one clk when at PRESCALE-1; PRESCALE=1 SHALL give tick every clk.
REQ-016 Each channel SHALL hold registered mode, period, duty, a CNT_W counter cnt and its led bit.
REQ-017 Accepted write to cfg_ch < NUM_CH SHALL, at that edge, load mode/period/duty, set cnt=0, set led = (mode==ON) | (mode==PWM & duty!=0), clear frame_pulse for that channel.
REQ-018 Accepted write with cfg_ch >= NUM_CH SHALL be consumed and change no state.
REQ-019 cfg_ready SHALL be 1 every cycle out of reset (no backpressure); writes one per clk.
REQ-020 OFF: led=0, cnt held 0, no frame_pulse; ON: led=1, cnt held 0, no frame_pulse.
REQ-021 BLINK on tick: if cnt==period then led toggles, cnt=0, frame_pulse=1 next cycle-only; else cnt=cnt+1. Half-period = (period+1) ticks; period=0 toggles every tick.
REQ-022 PWM on tick: cnt_next = (cnt==period) ? 0 : cnt+1; led = (cnt_next < duty); frame_pulse=1 when cnt wraps to 0. Frame = period+1 ticks, high min(duty, period+1) ticks.
REQ-023 PWM duty=0 SHALL give led constantly 0; duty > period SHALL give led constantly 1; frame_pulse still pulses.
REQ-024 frame_pulse bits SHALL be high exactly one clk per event and 0 on non-tick cycles.
REQ-025 sync=1 at an edge SHALL clear prescaler and every channel's cnt, set each led to its REQ-017 initial value, clear frame_pulse; modes/periods/duties retained.
REQ-026 sync and accepted write at the same edge: written channel takes new config, all channels restart per REQ-025.
REQ-027 Counter arithmetic SHALL be CNT_W unsigned; cnt never exceeds period (cnt==period compare prevents wrap past 2^CNT_W-1).

Reset
REQ-028 reset low SHALL immediately, independent of clk, force led=0, frame_pulse=0, cfg_ready=0, all modes=OFF, period=0, duty=0, cnt=0, prescaler=0.
REQ-029 First rising edge after reset deasserts SHALL set cfg_ready=1; reset mid-pattern SHALL discard all configuration.

Verification
REQ-030 Reset then write ch0 BLINK period=3, PRESCALE=1 -> led[0] 0 for 4 clks, 1 for 4 clks, repeating; frame_pulse[0] pulses on each toggle.
REQ-031 Write ch1 PWM period=9 duty=3 -> led[1] high 3 clks, low 7 clks per 10-clk frame; duty=0 -> always 0; duty=12 -> always 1.
REQ-032 PRESCALE=4, ch2 BLINK period=1 -> led[2] toggles every 8 clks.
REQ-033 ch0/ch1 BLINK period=5 written 2 clks apart, then sync -> both led bits and frame_pulses aligned thereafter.
REQ-034 Write cfg_ch=NUM_CH (out of range) -> no channel changes; write ch3 ON -> led[3]=1 after same edge.
REQ-035 Assert reset asynchronously mid-PWM -> led and frame_pulse 0 before next edge; after release all channels OFF, cfg_ready=1 one edge later.
